mem_addr_responder: RTL and testbench

// - Memory-side responder for the processor's address register: takes a latched word address plus

---
 rtl/mem_addr_responder_pkg.sv | 23 ++
 rtl/mem_word_ram.sv | 38 +++
 rtl/mem_addr_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_addr_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_addr_responder_pkg.sv
// Shared types for the address responder: FSM state, byte-lane geometry and
// access error codes (the error codes are also decoded by the bus decoder).
package mem_addr_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef logic [1:0] err_code_t;
  localparam err_code_t ERR_NONE  = 2'd0;
  localparam err_code_t ERR_RANGE = 2'd1;
  localparam err_code_t ERR_ALIGN = 2'd2;

  function automatic logic is_error(input err_code_t code);
    return code != ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word RAM with per-byte-lane write enables and a registered read port.
// Contents are never reset; rdata holds its value until the next read.
module mem_word_ram
  import mem_addr_responder_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [NUM_LANES-1:0] be,
  input  logic [IDX_W-1:0]     idx,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (be[i]) begin
            mem_q[idx][LANE_W*i +: LANE_W] <= wdata[LANE_W*i +: LANE_W];
          end
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_addr_responder.sv
// Single-outstanding memory responder: latches a request, waits WAIT_CYC cycles,
// accesses the word RAM and holds the response until it is taken.
// Optional feature: define MISALIGN_CHECK_EN to reject addresses with addr[1:0] != 0.
//
// Handshakes: a request transfers on a rising edge where req_valid & req_ready;
// a response transfers on a rising edge where rsp_valid & rsp_ready. rsp_valid,
// rsp_rdata and rsp_err hold steady from assertion until that transfer.
module mem_addr_responder
  import mem_addr_responder_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [NUM_LANES-1:0] req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output state_e               dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_LANES-1:0]  be_q, be_d;
  err_code_t             err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rd_ok_q, rd_ok_d;

  logic                  accept;
  logic                  access;
  err_code_t             req_err;
  logic [DATA_W-1:0]     ram_rdata;

  // Address classification is done at accept so later input changes cannot matter.
  always_comb begin
    req_err = ERR_NONE;
    if ((req_addr >> (IDX_W + 2)) != '0) begin
      req_err = ERR_RANGE;
    end
`ifdef MISALIGN_CHECK_EN
    else if (req_addr[1:0] != 2'b00) begin
      req_err = ERR_ALIGN;
    end
`endif
  end

`ifndef MISALIGN_CHECK_EN
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];
`endif

  assign accept = req_valid & req_ready_q & (state_q == ST_IDLE);
  // The last WAIT cycle presents the latched request to the RAM.
  assign access = (state_q == ST_WAIT) & (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_ok_d     = rd_ok_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          state_d     = ST_WAIT;
          cnt_d       = 4'(WAIT_CYC);
          we_d        = req_we;
          idx_d       = req_addr[2 +: IDX_W];
          wdata_d     = req_wdata;
          be_d        = req_be;
          err_d       = req_err;
          req_ready_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = is_error(err_q);
          rd_ok_d     = ~we_q & ~is_error(err_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_ok_d     = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rd_ok_d     = 1'b0;
        req_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= ERR_NONE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  // Reset forces IDLE, so an aborted write never reaches the RAM.
  mem_word_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (access),
    .we    (we_q & ~is_error(err_q)),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? ram_rdata : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_addr_responder.sv
// Directed plus randomized bench for mem_addr_responder (default parameters),
// checked against a word-array memory model.
module tb_mem_addr_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  mem_addr_responder_pkg::state_e dbg_state;

  int tests;
  int failed;
  logic [31:0] model_mem [256];

  localparam int EXP_LAT = 3;

  mem_addr_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // One full transaction; expectations come from the memory model.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          idx;
    int          lat;
    exp_err = (addr >= 32'h400);
`ifdef MISALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
    idx = int'(addr[9:2]);
    exp_rdata = 32'd0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        exp_rdata = model_mem[idx];
      end
    end

    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    step();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      step();
      lat++;
    end
    chk("latency", lat, EXP_LAT);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rdata);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        r_we;
    logic [31:0] r_addr;
    int          sel;

    tests     = 0;
    failed    = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;

    repeat (3) step();
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;
    step();
    chk("first_idle_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 64; i++) do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("directed_deadbeef", model_mem[4], 32'hDEADBEEF);

    do_txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
    chk("directed_lane_merge", model_mem[4], 32'hDE22BE44);

    do_txn(1'b0, 32'h400, 32'h0, 4'hF, 1);
    do_txn(1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 0);
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0);

    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5);
    do_txn(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, 2);
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, 0);

    // Abort a write during its wait states.
    do_txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (4) begin
      step();
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst = 1'b1;
    step();
    chk("abort_req_ready_back", {31'd0, req_ready}, 32'd1);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

    do_txn(1'b0, 32'h12, 32'h0, 4'h0, 0);

    for (int n = 0; n < 150; n++) begin
      r_we = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 9);
      if (sel == 0) r_addr = 32'h400 | $urandom;
      else if (sel == 1) r_addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else r_addr = 32'($urandom_range(0, 63) * 4);
      do_txn(r_we, r_addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
